m_ext_muldiv_unit: RTL and testbench
====================================

// Module: m_ext_muldiv_unit
// PURPOSE
//  Iterative RV32/RV64 M-extension execute unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//  Sits beside the ALU in EX and replaces the fixed-width Multiplier.
//  Adds: XLEN parametrisation, selectable multiplier radix, valid/ready handshake, tag passthrough,
//  flush, and spec-exact divide corner cases.
// PARAMETERS
//  XLEN          32  operand/result width; must be 32 or 64
//  MUL_BPC       1   multiplier bits retired per cycle; must be 1, 2 or 4; XLEN % MUL_BPC == 0
//  TAG_W         5   width of opaque tag (rd index) carried from request to response
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous reset, active-high
//  in_valid      in   1       request valid
//  in_ready      out  1       unit can accept a request (state IDLE)
//  in_op         in   3       funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  in_a, in_b    in   XLEN    rs1, rs2
//  in_tag        in   TAG_W   request tag
//  flush         in   1       abort any in-flight or pending op
//  out_valid     out  1       result valid (state DONE)
//  out_ready     in   1       consumer takes result
//  out_res       out  XLEN    result
//  out_tag       out  TAG_W   tag of the request that produced out_res
//  out_illegal   out  1       op not supported in this build (see CONFIGURATION)
//  busy          out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, out_res=0, out_tag=0, out_illegal=0, busy=0, cnt=0.
//  Accept on edge where in_valid&&in_ready; operands, op and tag are registered there (cycle 0).
//  FSM: IDLE -accept-> CALC (N cycles) -> FIX (1 cycle) -> DONE. DONE -out_ready-> IDLE.
//   N = XLEN/MUL_BPC for mul ops, XLEN for div/rem ops. out_valid rises in cycle N+2.
//   Fast path: divisor==0, or signed overflow (a==MIN_INT && b==-1): IDLE->FIX->DONE; out_valid in cycle 2.
//  Mul: operands sign-/zero-extended per op to XLEN+1 bits; shift-add, MUL_BPC bits/cycle into 2*XLEN
//   accumulator; MUL returns acc[XLEN-1:0]; MULH* return acc[2*XLEN-1:XLEN].
//  Div: restoring, 1 quotient bit/cycle on magnitudes; FIX negates q if sign(a)^sign(b) (signed ops),
//   negates r if sign(a) (signed ops). Remainder sign always follows the dividend.
//  Div by zero: DIV/DIVU -> all-ones; REM/REMU -> a. Overflow: DIV -> MIN_INT, REM -> 0.
//  DONE holds out_res/out_tag stable until out_ready; in_ready=0 in DONE (no result/accept overlap).
//  flush: synchronous; in any state next state=IDLE, out_valid=0; flush wins over same-cycle accept.
//  Reset mid-operation: immediate return to reset values; no result emitted.
//  cnt: $clog2(XLEN)+1 bits, loaded with N on accept, decremented in CALC, CALC exits when cnt==1.
// CONFIGURATION
//  M_EXT_DIV_EN defined: full divider (sub-module + div FSM paths) built; out_illegal always 0.
//  Not defined: no divider logic; ops 1xx accepted and take the fast path (DONE in cycle 2) with
//   out_res=0 and out_illegal=1; mul ops unaffected.
// STRUCTURE
//  Package m_ext_pkg: muldiv_op_e (funct3 enum), muldiv_state_e {IDLE,CALC,FIX,DONE},
//   functions op_is_div(), op_a_signed(), op_b_signed().
//  Sub-module m_ext_div_core: restoring divider datapath (start, step, quotient, remainder regs),
//   instantiated only under M_EXT_DIV_EN. Multiplier datapath and FSM stay in this module.
// TESTING  (XLEN=32 unless noted; run MUL_BPC=1 and 4)
//  MUL a=-250000 b=280000 -> 0xB3ACC400 in cycle 34 (BPC=1) / 10 (BPC=4); MULH same -> 0xFFFFFFEF.
//  MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF(-1)*2 -> 0xFFFFFFFF.
//  DIV -4/2 -> 0xFFFFFFFE; DIVU 0xFFFFFFFC/2 -> 0x7FFFFFFE; REM -7/2 -> 0xFFFFFFFF; each in cycle 34.
//  DIV 7/0 -> 0xFFFFFFFF, REM 7/0 -> 7, DIV 0x80000000/-1 -> 0x80000000, REM same -> 0; all in cycle 2.
//  Hold out_ready=0 10 cycles after DONE -> out_res/out_tag stable, in_ready=0; then tag returned intact.
//  flush in CALC cycle 5, new op accepted next cycle -> no stale out_valid; new result correct.

Source files
------------

// File: rtl/m_ext_pkg.sv
// Shared types and op decode helpers for the M-extension mul/div unit.
package m_ext_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    // Divide/remainder ops live in the upper half of funct3.
    function automatic logic op_is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input muldiv_op_e op);
        return op[2] & op[1];
    endfunction

    // rs1 treated as signed: MULH, MULHSU, DIV, REM.
    function automatic logic op_a_signed(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 treated as signed: MULH, DIV, REM.
    function automatic logic op_b_signed(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/m_ext_div_core.sv
// Restoring divider datapath: one quotient bit per step on unsigned magnitudes.
module m_ext_div_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] divisor_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        shifted = {remainder, quotient[XLEN-1]};
        diff    = shifted - {1'b0, divisor_q};
    end

    // Quotient register doubles as the dividend shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
            divisor_q <= '0;
        end else if (start) begin
            quotient  <= dividend;
            remainder <= '0;
            divisor_q <= divisor;
        end else if (step) begin
            if (!diff[XLEN]) begin
                remainder <= diff[XLEN-1:0];
                quotient  <= {quotient[XLEN-2:0], 1'b1};
            end else begin
                remainder <= shifted[XLEN-1:0];
                quotient  <= {quotient[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/m_ext_muldiv_unit.sv
// Iterative RV32/RV64 M-extension execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Build option: define M_EXT_DIV_EN to include the divider; otherwise divide ops
// complete immediately with out_res=0 and out_illegal=1.
module m_ext_muldiv_unit
    import m_ext_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MUL_BPC = 1,
    parameter int unsigned TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam int unsigned ACC_W = 2 * XLEN;
    localparam logic [CNT_W-1:0] N_MUL = CNT_W'(XLEN / MUL_BPC);
    localparam logic [CNT_W-1:0] N_DIV = CNT_W'(XLEN);

    muldiv_state_e    state;
    logic [CNT_W-1:0] cnt;
    muldiv_op_e       op_q;
    logic [TAG_W-1:0] tag_q;
    logic             fast_q;
    logic             b_neg_q;
    logic [ACC_W-1:0] acc_q, mcand_q;
    logic [XLEN-1:0]  mplier_q;

    muldiv_op_e       op_in;
    logic             accept, in_is_div, in_sa, in_sb, in_fast;
    logic [ACC_W-1:0] acc_step, acc_fix;
    logic [XLEN-1:0]  res_fix;
    logic             illegal_fix;

`ifdef M_EXT_DIV_EN
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
    logic [XLEN-1:0] a_q, a_mag, b_mag, div_quo, div_rem;
    logic            dz_q, q_neg_q, r_neg_q, in_dz, in_ovf, div_start, div_step;
`endif

    // Request decode; flush suppresses a same-cycle accept.
    always_comb begin
        op_in     = muldiv_op_e'(in_op);
        accept    = in_valid && in_ready && !flush;
        in_is_div = op_is_div(op_in);
        in_sa     = op_a_signed(op_in);
        in_sb     = op_b_signed(op_in);
`ifdef M_EXT_DIV_EN
        in_dz     = (in_b == '0);
        in_ovf    = in_sa && (in_a == MIN_INT) && (in_b == '1);
        in_fast   = in_is_div && (in_dz || in_ovf);
        a_mag     = (in_sa && in_a[XLEN-1]) ? -in_a : in_a;
        b_mag     = (in_sb && in_b[XLEN-1]) ? -in_b : in_b;
        div_start = accept && in_is_div && !in_fast;
        div_step  = (state == CALC) && op_is_div(op_q);
`else
        in_fast   = in_is_div;
`endif
    end

    // Shift-add step: retire MUL_BPC multiplier bits into the accumulator.
    always_comb begin
        acc_step = acc_q;
        for (int j = 0; j < int'(MUL_BPC); j++) begin
            if (mplier_q[j]) acc_step = acc_step + (mcand_q << j);
        end
    end

    // Final result selection; after N steps mcand_q holds a<<XLEN, the weight of a negative rs2 sign bit.
    always_comb begin
        acc_fix     = acc_q - (b_neg_q ? mcand_q : '0);
        res_fix     = '0;
        illegal_fix = 1'b0;
        if (!op_is_div(op_q)) begin
            res_fix = (op_q == OP_MUL) ? acc_fix[XLEN-1:0] : acc_fix[ACC_W-1:XLEN];
        end else begin
`ifdef M_EXT_DIV_EN
            if (fast_q) begin
                if (dz_q) res_fix = op_is_rem(op_q) ? a_q : '1;
                else      res_fix = op_is_rem(op_q) ? '0 : MIN_INT;
            end else if (op_is_rem(op_q)) begin
                res_fix = r_neg_q ? -div_rem : div_rem;
            end else begin
                res_fix = q_neg_q ? -div_quo : div_quo;
            end
`else
            illegal_fix = 1'b1;
`endif
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            out_res     <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt      <= in_is_div ? N_DIV : N_MUL;
                        state    <= in_fast ? FIX : CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= FIX;
                end
                FIX: begin
                    state       <= DONE;
                    out_valid   <= 1'b1;
                    out_res     <= res_fix;
                    out_tag     <= tag_q;
                    out_illegal <= illegal_fix;
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand capture and multiplier datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_MUL;
            tag_q    <= '0;
            fast_q   <= 1'b0;
            b_neg_q  <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (accept) begin
            op_q     <= op_in;
            tag_q    <= in_tag;
            fast_q   <= in_fast;
            b_neg_q  <= in_sb && in_b[XLEN-1];
            acc_q    <= '0;
            mcand_q  <= {{XLEN{in_sa & in_a[XLEN-1]}}, in_a};
            mplier_q <= in_b;
        end else if ((state == CALC) && !op_is_div(op_q)) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << MUL_BPC;
            mplier_q <= mplier_q >> MUL_BPC;
        end
    end

`ifdef M_EXT_DIV_EN
    // Divide corner-case and result-sign bookkeeping captured at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            dz_q    <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (accept) begin
            a_q     <= in_a;
            dz_q    <= in_dz;
            q_neg_q <= in_sa && (in_a[XLEN-1] ^ in_b[XLEN-1]);
            r_neg_q <= in_sa && in_a[XLEN-1];
        end
    end

    m_ext_div_core #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .step      (div_step),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (div_quo),
        .remainder (div_rem)
    );
`endif

endmodule

// File: tb/tb_m_ext_muldiv_unit.sv
// Scoreboard bench for m_ext_muldiv_unit (XLEN=32); expectations follow the M_EXT_DIV_EN build option.
module tb_m_ext_muldiv_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned BPC   = 4;
    localparam int unsigned TAG_W = 5;
`ifdef M_EXT_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, flush, out_valid, out_ready, out_illegal, busy;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_a, in_b, out_res;
    logic [TAG_W-1:0] in_tag, out_tag;

    typedef struct {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
        logic             ill;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   t0    = 0;

    m_ext_muldiv_unit #(.XLEN(XLEN), .MUL_BPC(BPC), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_res     (out_res),
        .out_tag     (out_tag),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model built on native SV arithmetic; latency counted as the cycle out_valid is first high.
    function automatic exp_t model(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                   input logic [TAG_W-1:0] tag);
        exp_t        e;
        logic [63:0] ax, bx, p;
        logic        sa, sbs, sgn, rem;
        e.tag = tag;
        e.ill = 1'b0;
        e.res = '0;
        e.lat = 0;
        if (!op[2]) begin
            sa  = (op == 3'd1) || (op == 3'd2);
            sbs = (op == 3'd1);
            ax  = sa  ? {{32{a[31]}}, a} : {32'b0, a};
            bx  = sbs ? {{32{b[31]}}, b} : {32'b0, b};
            p   = ax * bx;
            e.res = (op == 3'd0) ? p[31:0] : p[63:32];
            e.lat = int'(XLEN / BPC) + 2;
        end else if (DIV_EN) begin
            sgn = !op[0];
            rem = op[1];
            if (b == '0) begin
                e.res = rem ? a : '1;
                e.lat = 2;
            end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.res = rem ? 32'h0 : 32'h8000_0000;
                e.lat = 2;
            end else begin
                if (sgn) e.res = rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
                else     e.res = rem ? (a % b) : (a / b);
                e.lat = int'(XLEN) + 2;
            end
        end else begin
            e.ill = 1'b1;
            e.lat = 2;
        end
        return e;
    endfunction

    // Drive one request; kres replaces the model result when usek is set.
    task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] kres, input bit usek);
        exp_t e;
        int   k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) check("issue_ready", 64'(in_ready), 64'd1);
        e = model(op, a, b, tag);
        if (usek) e.res = kres;
        sb.push_back(e);
        in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a result, compare against the scoreboard, optionally stall out_ready.
    task automatic collect(input int hold);
        exp_t e;
        int   lat = 0;
        bit   seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat  = cyc - t0 + 1;
                seen = 1'b1;
                break;
            end
        end
        check("valid_seen", 64'(seen), 64'd1);
        if (sb.size() == 0) begin
            check("sb_nonempty", 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        check("latency", 64'(lat), 64'(e.lat));
        check("res", 64'(out_res), 64'(e.res));
        check("tag", 64'(out_tag), 64'(e.tag));
        check("illegal", 64'(out_illegal), 64'(e.ill));
        check("ready_in_done", 64'(in_ready), 64'd0);
        check("busy_in_done", 64'(busy), 64'd1);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_res", 64'(out_res), 64'(e.res));
            check("hold_tag", 64'(out_tag), 64'(e.tag));
            check("hold_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_ready", 64'(in_ready), 64'd1);
    endtask

    logic [2:0]      d_op  [11] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6};
    logic [XLEN-1:0] d_a   [11] = '{32'hFFFC2F70, 32'hFFFC2F70, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFC,
                                    32'hFFFFFFFC, 32'hFFFFFFF9, 32'd7, 32'd7, 32'h80000000, 32'h80000000};
    logic [XLEN-1:0] d_b   [11] = '{32'h000445C0, 32'h000445C0, 32'hFFFFFFFF, 32'd2, 32'd2,
                                    32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [XLEN-1:0] d_res [11] = '{32'hB3ACC400, 32'hFFFFFFEF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE,
                                    32'h7FFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd0};

    initial begin
        exp_t            d;
        logic [2:0]      rop;
        logic [XLEN-1:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_res", 64'(out_res), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_illegal", 64'(out_illegal), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors with hand-derived results (divide constants only in the divider build).
        for (int i = 0; i < 11; i++) begin
            issue(d_op[i], d_a[i], d_b[i], TAG_W'(i + 1), d_res[i], !d_op[i][2] || DIV_EN);
            collect(0);
        end

        // Result held under back-pressure, tag returned intact.
        issue(3'd1, 32'h12345678, 32'h9ABCDEF0, 5'h1A, '0, 1'b0);
        collect(10);

        // Flush during CALC, then a fresh op right away.
        issue(3'd3, 32'hDEADBEEF, 32'hCAFEF00D, 5'h03, '0, 1'b0);
        d = sb.pop_back();
        repeat (4) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);
        check("flush_busy", 64'(busy), 64'd0);
        issue(3'd0, 32'd1234567, 32'd7654321, 5'h04, '0, 1'b0);
        collect(0);

        // Flush wins over a same-cycle request.
        in_op = 3'd0; in_a = 32'd3; in_b = 32'd5; in_tag = 5'h05;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_accept_busy", 64'(busy), 64'd0);
        check("flush_accept_ready", 64'(in_ready), 64'd1);

        // Random mixed ops through the model.
        for (int i = 0; i < 12; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i == 5) ? 32'd0 : $urandom >> $urandom_range(0, 28);
            issue(rop, ra, rb, TAG_W'($urandom), '0, 1'b0);
            collect(i % 3);
        end

        // Asynchronous reset mid-operation discards the op.
        issue(3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'h1F, '0, 1'b0);
        d = sb.pop_back();
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_res", 64'(out_res), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 5'h11, '0, 1'b0);
        collect(0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
